uid_frame_parser: RTL and testbench

//  Byte-stream frame parser upstream of the UID auth lookup.
//  - Consumes bytes from the RFID reader serial receiver.
//  - Validates framing, length and XOR checksum.
//  - Presents a command byte, the UID and a one-cycle valid strobe to the auth lookup.
//  - Bad frames are dropped and flagged; the auth lookup never sees them.

---
 rtl/rfid_pkg.sv | 23 ++
 rtl/frame_timer.sv | 37 +++
 rtl/uid_frame_parser.sv | 142 ++++++++++++++
 tb/tb_uid_frame_parser.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rfid_pkg.sv
// rtl/rfid_pkg.sv - shared RFID frame constants, parser states and drop codes
package rfid_pkg;

  localparam logic [7:0] RFID_SOF  = 8'hA5;
  localparam logic [7:0] CMD_CHECK = 8'h01;
  localparam logic [7:0] CMD_ADD   = 8'h02;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    LEN,
    DATA,
    CHK
  } parse_state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_CHK,
    ERR_LEN,
    ERR_TIMEOUT
  } err_code_t;

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - inter-byte idle timer that aborts a stalled frame
module frame_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!run || clear) begin
      count_d = '0;
    end else if (count_q != LAST) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A byte arriving on the expiry cycle takes priority over the abort.
  assign expired = run && !clear && (count_q == LAST);

endmodule

// File: rtl/uid_frame_parser.sv
// rtl/uid_frame_parser.sv - SOF/CMD/LEN/UID/CHK byte-stream parser feeding the UID auth lookup
module uid_frame_parser
  import rfid_pkg::*;
#(
  parameter int UID_BYTES      = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [7:0]             cmd,
  output logic [UID_BYTES*8-1:0] uid,
  output logic                   valid,
  output logic                   frame_err,
  output logic [1:0]             err_code,
  output logic                   busy
);

  localparam int UID_W = UID_BYTES * 8;
  localparam int CNT_W = $clog2(UID_BYTES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UID_BYTES - 1);
  localparam logic [7:0] LEN_FULL = 8'(UID_BYTES);

  parse_state_t     state_q, state_d;
  logic [7:0]       cmd_stage_q, cmd_stage_d;
  logic [UID_W-1:0] uid_stage_q, uid_stage_d;
  logic [7:0]       chk_q, chk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [UID_W-1:0] uid_q, uid_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  err_code_t        err_q, err_d;
  logic             expired;

  frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (state_q != IDLE),
    .clear  (rx_valid),
    .expired(expired)
  );

  always_comb begin
    state_d     = state_q;
    cmd_stage_d = cmd_stage_q;
    uid_stage_d = uid_stage_q;
    chk_d       = chk_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    uid_d       = uid_q;
    valid_d     = 1'b0;
    ferr_d      = 1'b0;
    err_d       = err_q;

    if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (rx_data == RFID_SOF) state_d = CMD;
        end
        CMD: begin
          cmd_stage_d = rx_data;
          uid_stage_d = '0;
          chk_d       = rx_data;
          state_d     = LEN;
        end
        LEN: begin
          chk_d = chk_q ^ rx_data;
          cnt_d = '0;
          if (rx_data == 8'd0) begin
            state_d = CHK;
          end else if (rx_data == LEN_FULL) begin
            state_d = DATA;
          end else begin
            ferr_d  = 1'b1;
            err_d   = ERR_LEN;
            state_d = IDLE;
          end
        end
        DATA: begin
          uid_stage_d = (uid_stage_q << 8) | UID_W'(rx_data);
          chk_d       = chk_q ^ rx_data;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = CHK;
        end
        CHK: begin
          if (rx_data == chk_q) begin
            cmd_d   = cmd_stage_q;
            uid_d   = uid_stage_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
            err_d  = ERR_CHK;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (expired) begin
      ferr_d  = 1'b1;
      err_d   = ERR_TIMEOUT;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_stage_q <= '0;
      uid_stage_q <= '0;
      chk_q       <= '0;
      cnt_q       <= '0;
      cmd_q       <= '0;
      uid_q       <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      err_q       <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      cmd_stage_q <= cmd_stage_d;
      uid_stage_q <= uid_stage_d;
      chk_q       <= chk_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      uid_q       <= uid_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      err_q       <= err_d;
    end
  end

  assign cmd       = cmd_q;
  assign uid       = uid_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign err_code  = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uid_frame_parser.sv
// tb/tb_uid_frame_parser.sv - self-checking bench for uid_frame_parser
module tb_uid_frame_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [7:0]  cmd;
  logic [31:0] uid;
  logic        valid;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        busy;

  always #5 clk = ~clk;

  uid_frame_parser #(
    .UID_BYTES     (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .cmd      (cmd),
    .uid      (uid),
    .valid    (valid),
    .frame_err(frame_err),
    .err_code (err_code),
    .busy     (busy)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int vcnt     = 0;
  int ecnt     = 0;

  // Reference model: collects the bytes following SOF and judges the frame once complete.
  bit          m_in;
  logic [7:0]  m_frame[$];
  int          m_idle;
  logic [7:0]  m_cmd;
  logic [31:0] m_uid;
  logic        m_valid, m_ferr, m_busy;
  logic [1:0]  m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input logic [7:0] d);
    int n;
    logic [7:0] x;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    if (!r) begin
      m_in = 1'b0; m_frame.delete(); m_idle = 0;
      m_cmd = '0; m_uid = '0; m_err = '0;
    end else if (v) begin
      m_idle = 0;
      if (!m_in) begin
        if (d == 8'hA5) begin
          m_in = 1'b1;
          m_frame.delete();
        end
      end else begin
        m_frame.push_back(d);
        n = m_frame.size();
        if (n == 2 && m_frame[1] != 8'd0 && m_frame[1] != 8'd4) begin
          m_ferr = 1'b1; m_err = 2'd2; m_in = 1'b0;
        end else if (n >= 3 && n == 3 + int'(m_frame[1])) begin
          x = 8'h00;
          for (int i = 0; i < n - 1; i++) x = x ^ m_frame[i];
          if (x == d) begin
            m_valid = 1'b1;
            m_cmd   = m_frame[0];
            m_uid   = '0;
            for (int i = 2; i < n - 1; i++) m_uid = {m_uid[23:0], m_frame[i]};
          end else begin
            m_ferr = 1'b1; m_err = 2'd1;
          end
          m_in = 1'b0;
        end
      end
    end else if (m_in) begin
      m_idle++;
      if (m_idle == 16) begin
        m_ferr = 1'b1; m_err = 2'd3; m_in = 1'b0; m_idle = 0;
      end
    end
    m_busy = m_in;
  endtask

  task automatic cycle(input bit r, input bit v, input logic [7:0] d);
    rst_n    = r;
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    model_step(r, v, d);
    @(negedge clk);
    vcnt += int'(valid);
    ecnt += int'(frame_err);
    check("cycle", 64'({valid, frame_err, err_code, busy, cmd, uid}),
          64'({m_valid, m_ferr, m_err, m_busy, m_cmd, m_uid}));
  endtask

  task automatic send(input logic [95:0] seq, input int len);
    for (int i = 0; i < len; i++) cycle(1'b1, 1'b1, seq[95-8*i -: 8]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'h00);
  endtask

  typedef struct {
    string       name;
    logic [95:0] seq;
    int          len;
    int          exp_valid;
    int          exp_err;
    logic [1:0]  exp_code;
    logic [7:0]  exp_cmd;
    logic [31:0] exp_uid;
  } vec_t;

  vec_t vecs[5];

  task automatic rand_frame();
    int kind;
    logic [7:0] c, l, x;
    logic [7:0] b[4];
    kind = $urandom_range(0, 6);
    c = 8'($urandom);
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
    l = (kind == 1) ? 8'd0 : 8'd4;
    if (kind == 3) begin
      do l = 8'($urandom); while (l == 8'd0 || l == 8'd4);
    end
    x = c ^ l;
    if (l == 8'd4) for (int i = 0; i < 4; i++) x = x ^ b[i];
    if (kind == 2) x = x ^ 8'(1 << $urandom_range(0, 7));
    if (kind == 4) begin
      cycle(1'b1, 1'b1, 8'($urandom));
      return;
    end
    cycle(1'b1, 1'b1, 8'hA5);
    cycle(1'b1, 1'b1, c);
    if (kind == 5) begin
      idle($urandom_range(14, 18));
      return;
    end
    if (kind == 6) begin
      cycle(1'b0, 1'b0, 8'h00);
      return;
    end
    cycle(1'b1, 1'b1, l);
    if (kind == 3) return;
    if (l == 8'd4) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        cycle(1'b1, 1'b1, b[i]);
      end
    end
    cycle(1'b1, 1'b1, x);
  endtask

  initial begin
    vecs[0] = '{"good_frame", 96'hA5_01_04_DE_AD_BE_EF_27_00_00_00_00, 8, 1, 0, 2'd0, 8'h01, 32'hDEADBEEF};
    vecs[1] = '{"bad_chk",    96'hA5_01_04_DE_AD_BE_EF_28_00_00_00_00, 8, 0, 1, 2'd1, 8'h01, 32'hDEADBEEF};
    vecs[2] = '{"bad_len",    96'hA5_02_03_00_00_00_00_00_00_00_00_00, 3, 0, 1, 2'd2, 8'h01, 32'hDEADBEEF};
    vecs[3] = '{"len_zero",   96'hA5_02_00_02_00_00_00_00_00_00_00_00, 4, 1, 0, 2'd2, 8'h02, 32'h00000000};
    vecs[4] = '{"noise_a5",   96'h00_FF_5A_A5_01_04_A5_A5_A5_A5_05_00, 11, 1, 0, 2'd2, 8'h01, 32'hA5A5A5A5};

    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    check("reset", 64'({valid, frame_err, err_code, busy, cmd, uid}), 64'h0);

    foreach (vecs[k]) begin
      vcnt = 0; ecnt = 0;
      send(vecs[k].seq, vecs[k].len);
      idle(2);
      check({vecs[k].name, "_valid"}, 64'(vcnt), 64'(vecs[k].exp_valid));
      check({vecs[k].name, "_err"},   64'(ecnt), 64'(vecs[k].exp_err));
      check({vecs[k].name, "_code"},  64'(err_code), 64'(vecs[k].exp_code));
      check({vecs[k].name, "_cmd"},   64'(cmd), 64'(vecs[k].exp_cmd));
      check({vecs[k].name, "_uid"},   64'(uid), 64'(vecs[k].exp_uid));
    end

    vcnt = 0; ecnt = 0;
    send(96'hA5_01_04_DE_00_00_00_00_00_00_00_00, 4);
    idle(15);
    check("tmo_early", 64'(ecnt), 64'd0);
    idle(1);
    check("tmo_err", 64'(ecnt), 64'd1);
    check("tmo_code", 64'(err_code), 64'd3);
    check("tmo_busy", 64'(busy), 64'd0);

    vcnt = 0; ecnt = 0;
    send(96'hA5_01_04_DE_00_00_00_00_00_00_00_00, 4);
    idle(15);
    send(96'hAD_BE_EF_27_00_00_00_00_00_00_00_00, 4);
    idle(1);
    check("tmo_race_err", 64'(ecnt), 64'd0);
    check("tmo_race_valid", 64'(vcnt), 64'd1);
    check("tmo_race_uid", 64'(uid), 64'hDEADBEEF);

    vcnt = 0; ecnt = 0;
    send(96'hA5_02_04_11_22_33_44_42_A5_01_00_01, 12);
    idle(2);
    check("b2b_valid", 64'(vcnt), 64'd2);
    check("b2b_cmd", 64'(cmd), 64'h01);
    check("b2b_uid", 64'(uid), 64'h0);

    send(96'hA5_01_04_DE_00_00_00_00_00_00_00_00, 4);
    vcnt = 0; ecnt = 0;
    cycle(1'b0, 1'b0, 8'h00);
    check("rst_mid", 64'({valid, frame_err, err_code, busy, cmd, uid}), 64'h0);
    idle(20);
    check("rst_mid_pulses", 64'(vcnt + ecnt), 64'd0);
    send(96'hA5_01_04_DE_AD_BE_EF_27_00_00_00_00, 8);
    idle(1);
    check("rst_next_valid", 64'(vcnt), 64'd1);
    check("rst_next_uid", 64'(uid), 64'hDEADBEEF);

    for (int it = 0; it < 400; it++) begin
      rand_frame();
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
